i2c_controller: RTL and testbench

- Single-master I2C controller that performs one register-addressed transaction per request: write or read of 1 or 2 data bytes to/from a 7-bit peripheral.
- Sits between local control logic and the board I2C pins.
- Generates SCL from the system clock at a selectable speed. Drives SDA open-drain, no clock stretching, no multi-master arbitration.

---
 rtl/i2c_controller_pkg.sv | 24 ++
 rtl/i2c_scl_divider.sv | 36 +++
 rtl/i2c_controller.sv | 161 ++++++++++++++++
 tb/tb_i2c_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_controller_pkg.sv
// i2c_controller_pkg: shared FSM states, SCL speed encoding and quarter-period math
package i2c_controller_pkg;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK_ADDR, REG, ACK_REG, RSTART, ADDR_R, ACK_ADDR_R,
      WDATA, ACK_WDATA, RDATA, MACK, STOP, BUS_FREE
   } state_e;

   localparam logic [1:0] MODE_100K = 2'd0;
   localparam logic [1:0] MODE_400K = 2'd1;
   localparam logic [1:0] MODE_1M   = 2'd2;

   localparam int unsigned F_100K = 100_000;
   localparam int unsigned F_400K = 400_000;
   localparam int unsigned F_1M   = 1_000_000;

   // Clamped to one clock so a slow system clock still produces a legal divider
   function automatic int unsigned quarter_count(input int unsigned clk_hz, input logic [1:0] mode);
      int unsigned f_scl;
      f_scl = (mode == MODE_400K) ? F_400K : (mode == MODE_1M) ? F_1M : F_100K;
      return (clk_hz < 4 * f_scl) ? 32'd1 : clk_hz / (4 * f_scl);
   endfunction

endpackage

// File: rtl/i2c_scl_divider.sv
// i2c_scl_divider: quarter-period tick and phase index (0..3) for the SCL bit frame
module i2c_scl_divider
   import i2c_controller_pkg::*;
#(
   parameter int unsigned CLK_HZ = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_i,
   input  logic       run_i,
   output logic       tick_o,
   output logic [1:0] phase_o
);

   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  phase_q, phase_d;

   always_comb begin
      tick_o  = run_i && (cnt_q == quarter_count(CLK_HZ, mode_i) - 32'd1);
      cnt_d   = (!run_i || tick_o) ? '0 : cnt_q + 32'd1;
      phase_d = !run_i ? 2'd0 : tick_o ? phase_q + 2'd1 : phase_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-master I2C register write/read of 1 or 2 bytes
// SCL and SDA enable are registered so the pins never glitch on state decode.
module i2c_controller
   import i2c_controller_pkg::*;
#(
   parameter int unsigned CLK_HZ = 500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [6:0]  peripheral_address,
   input  logic [7:0]  target_register,
   input  logic        rw,
   input  logic        data_length,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        scl,
   inout  wire         sda,
   output logic        busy,
   output logic        nack
);

   state_e      state_q, state_d;
   logic [2:0]  bit_q, bit_d;
   logic        byte_q, byte_d, ack_q, ack_d, nack_q, nack_d, rw_q, rw_d;
   logic        lag_q, lag_d, scl_q, scl_d, oe_q, oe_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  reg_q, reg_d, tx;
   logic [15:0] din_q, din_d, rx_q, rx_d, dout_q, dout_d;
   logic [1:0]  mode_q, mode_d, phase;
   logic        tick, last, samp, sda_in;

   i2c_scl_divider #(.CLK_HZ(CLK_HZ)) u_div (
      .clk    (clk),
      .rst    (rst),
      .mode_i (mode_q),
      .run_i  (state_q != IDLE),
      .tick_o (tick),
      .phase_o(phase)
   );

   assign sda    = oe_q ? 1'b0 : 1'bz;
   assign sda_in = sda;
   assign scl    = scl_q;
   assign nack   = nack_q;
   assign dout   = dout_q;
   // lag_q stretches busy to cover the registered pin delay of the bus-free window
   assign busy   = (state_q != IDLE) || lag_q;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      ack_d   = ack_q;
      nack_d  = nack_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      reg_d   = reg_q;
      din_d   = din_q;
      mode_d  = mode_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      lag_d   = state_q != IDLE;
      last    = tick && (phase == 2'd3);
      samp    = tick && (phase == 2'd2);
      tx      = (state_q == ADDR) ? {addr_q, 1'b0} : (state_q == REG) ? reg_q :
                (state_q == ADDR_R) ? {addr_q, 1'b1} : byte_q ? din_q[15:8] : din_q[7:0];
      scl_d   = (state_q inside {IDLE, START, BUS_FREE}) ? 1'b1 :
                (state_q == RSTART) ? (phase != 2'd0) : phase[1];
      oe_d    = (state_q inside {START, RSTART}) ? phase[1] : (state_q == STOP) ? 1'b1 :
                (state_q inside {ADDR, REG, ADDR_R, WDATA}) ? ~tx[bit_q] :
                (state_q == MACK) ? byte_q : 1'b0;
      unique case (state_q)
         IDLE: if (en && !lag_q) begin
            state_d = START;
            addr_d  = peripheral_address;
            reg_d   = target_register;
            rw_d    = rw;
            din_d   = din;
            mode_d  = mode;
            byte_d  = data_length;
            bit_d   = 3'd7;
            nack_d  = 1'b0;
            rx_d    = '0;
         end
         START:  if (last) state_d = ADDR;
         RSTART: if (last) state_d = ADDR_R;
         ADDR, REG, ADDR_R, WDATA: if (last) begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0)
               state_d = (state_q == ADDR) ? ACK_ADDR : (state_q == REG) ? ACK_REG :
                         (state_q == ADDR_R) ? ACK_ADDR_R : ACK_WDATA;
         end
         ACK_ADDR, ACK_REG, ACK_ADDR_R, ACK_WDATA: begin
            if (samp) ack_d = sda_in;
            if (last) begin
               nack_d  = nack_q | ack_q;
               byte_d  = (state_q == ACK_WDATA) ? 1'b0 : byte_q;
               state_d = ack_q ? STOP : (state_q == ACK_ADDR) ? REG :
                         (state_q == ACK_REG) ? (rw_q ? RSTART : WDATA) :
                         (state_q == ACK_ADDR_R) ? RDATA : byte_q ? WDATA : STOP;
            end
         end
         RDATA: begin
            if (samp) rx_d = {rx_q[14:0], sda_in};
            if (last) begin
               bit_d = bit_q - 3'd1;
               if (bit_q == 3'd0) state_d = MACK;
            end
         end
         MACK: if (last) begin
            state_d = byte_q ? RDATA : STOP;
            byte_d  = 1'b0;
         end
         STOP: if (last) begin
            state_d = BUS_FREE;
            if (rw_q && !nack_q) dout_d = rx_q;
         end
         BUS_FREE: if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= 3'd7;
         byte_q  <= 1'b0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         reg_q   <= '0;
         din_q   <= '0;
         mode_q  <= MODE_100K;
         rx_q    <= '0;
         dout_q  <= '0;
         lag_q   <= 1'b0;
         scl_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         ack_q   <= ack_d;
         nack_q  <= nack_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         reg_q   <= reg_d;
         din_q   <= din_d;
         mode_q  <= mode_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         lag_q   <= lag_d;
         scl_q   <= scl_d;
         oe_q    <= oe_d;
      end
   end

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed transactions against a bus decoder and peripheral model
// An 8 MHz system clock scales the timing: Q=20 at 100 kHz, Q=5 at 400 kHz.
module tb_i2c_controller;

   localparam int unsigned CLK_HZ = 8_000_000;
   localparam int Q0 = 20;
   localparam int Q1 = 5;
   localparam int EV_START = 'h1000;
   localparam int EV_STOP  = 'h2000;

   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, rw = 1'b0, data_length = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [6:0]  paddr = '0;
   logic [7:0]  treg = '0;
   logic [15:0] din = '0;
   wire  [15:0] dout;
   wire         scl, busy, nack;
   wire         sda;
   logic        pdrv = 1'b0;

   pullup (sda);
   assign sda = pdrv ? 1'b0 : 1'bz;

   i2c_controller #(.CLK_HZ(CLK_HZ)) dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .mode              (mode),
      .peripheral_address(paddr),
      .target_register   (treg),
      .rw                (rw),
      .data_length       (data_length),
      .din               (din),
      .dout              (dout),
      .scl               (scl),
      .sda               (sda),
      .busy              (busy),
      .nack              (nack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         tests = 0, fails = 0;
   int         log_q[$];
   int         exp_a[8];
   int         bitcnt = 0, byte_idx = 0, stop_cyc = 0, last_rise = 0, scl_per = 0;
   bit         rd = 1'b0, done = 1'b1, nack_addr = 1'b0;
   logic       ps = 1'b1, psda = 1'b1, sv;
   logic [7:0] shift = '0;
   logic [7:0] rdat[2];

   // Bus decoder and peripheral: samples pins on the falling system clock edge
   initial forever begin
      @(negedge clk);
      sv = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (rst) begin
         log_q.delete();
         bitcnt = 0; byte_idx = 0; rd = 0; done = 1; pdrv = 0;
      end else if (ps && scl && psda && !sv) begin
         log_q.push_back(EV_START);
         bitcnt = 0; byte_idx = 0; rd = 0; done = 0; pdrv = 0;
      end else if (ps && scl && !psda && sv) begin
         log_q.push_back(EV_STOP);
         stop_cyc = cyc;
         done = 1;
      end else if (!ps && scl) begin
         if (byte_idx == 0 && bitcnt == 2) scl_per = cyc - last_rise;
         last_rise = cyc;
         if (bitcnt < 8) shift = {shift[6:0], sv};
         else begin
            log_q.push_back(int'({sv, shift}));
            if (byte_idx == 0) rd = shift[0];
            else if (rd && sv) done = 1;
         end
         bitcnt++;
      end else if (ps && !scl) begin
         if (bitcnt == 9) begin bitcnt = 0; byte_idx++; end
         pdrv = 0;
         if (!done && bitcnt == 8 && !(rd && byte_idx > 0)) pdrv = !(nack_addr && byte_idx == 0);
         else if (!done && bitcnt < 8 && rd && byte_idx inside {[1:2]}) pdrv = !rdat[byte_idx-1][7-bitcnt];
      end
      ps = scl;
      psda = sv;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input string tag, input int n);
      chk({tag, ".len"}, log_q.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s.ev%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, exp_a[i]);
   endtask

   task automatic go(input logic [6:0] a, input logic [7:0] r, input logic w, input logic l,
                     input logic [15:0] d, input logic [1:0] m, input bit hold);
      @(posedge clk); #1;
      log_q.delete();
      scl_per = 0;
      paddr = a; treg = r; rw = w; data_length = l; din = d; mode = m; en = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      chk("accept", busy, 1'b1);
      if (!hold) begin
         @(posedge clk); #1;
         en = 1'b0; paddr = '0; treg = '0; din = '0; rw = ~w; data_length = ~l; mode = 2'd2;
      end
   endtask

   task automatic finish_txn(input string tag, input int q);
      int n = 0;
      while (busy && n < 20000) begin @(negedge clk); n++; end
      chk({tag, ".idle"}, busy, 1'b0);
      chk({tag, ".free"}, cyc - stop_cyc, 4 * q);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst.scl", scl, 1'b1);
      chk("rst.sda", sda, 1'b1);
      chk("rst.busy", busy, 1'b0);
      chk("rst.nack", nack, 1'b0);
      chk("rst.dout", dout, 16'h0000);

      go(7'h49, 8'h96, 1'b0, 1'b1, 16'hAACC, 2'd0, 1'b0);
      finish_txn("w2", Q0);
      exp_a = '{EV_START, 'h92, 'h96, 'hAA, 'hCC, EV_STOP, 0, 0};
      chk_log("w2", 6);
      chk("w2.per", scl_per, 4 * Q0);
      chk("w2.nack", nack, 1'b0);
      chk("w2.dout", dout, 16'h0000);

      rdat[0] = 8'h5A; rdat[1] = 8'h3C;
      go(7'h49, 8'h96, 1'b1, 1'b1, 16'h0000, 2'd0, 1'b0);
      finish_txn("r2", Q0);
      exp_a = '{EV_START, 'h92, 'h96, EV_START, 'h93, 'h05A, 'h13C, EV_STOP};
      chk_log("r2", 8);
      chk("r2.dout", dout, 16'h5A3C);
      chk("r2.nack", nack, 1'b0);

      rdat[0] = 8'hE1;
      go(7'h49, 8'h96, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
      finish_txn("r1", Q0);
      exp_a = '{EV_START, 'h92, 'h96, EV_START, 'h93, 'h1E1, EV_STOP, 0};
      chk_log("r1", 7);
      chk("r1.dout", dout, 16'h00E1);

      go(7'h49, 8'h96, 1'b0, 1'b0, 16'hAACC, 2'd1, 1'b0);
      finish_txn("w1", Q1);
      exp_a = '{EV_START, 'h92, 'h96, 'hCC, EV_STOP, 0, 0, 0};
      chk_log("w1", 5);
      chk("w1.per", scl_per, 4 * Q1);
      chk("w1.dout", dout, 16'h00E1);

      nack_addr = 1'b1;
      go(7'h49, 8'h96, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
      finish_txn("na", Q0);
      exp_a = '{EV_START, 'h192, EV_STOP, 0, 0, 0, 0, 0};
      chk_log("na", 3);
      chk("na.nack", nack, 1'b1);
      chk("na.dout", dout, 16'h00E1);
      nack_addr = 1'b0;

      go(7'h49, 8'h96, 1'b0, 1'b0, 16'h1234, 2'd1, 1'b0);
      chk("na.clr", nack, 1'b0);
      finish_txn("wc", Q1);
      exp_a = '{EV_START, 'h92, 'h96, 'h34, EV_STOP, 0, 0, 0};
      chk_log("wc", 5);

      go(7'h49, 8'h96, 1'b0, 1'b1, 16'hAACC, 2'd0, 1'b1);
      repeat (355) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid.scl", scl, 1'b1);
      chk("mid.sda", sda, 1'b1);
      chk("mid.busy", busy, 1'b0);
      chk("mid.dout", dout, 16'h0000);
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      chk("mid.restart", busy, 1'b1);
      @(posedge clk); #1 en = 1'b0;
      finish_txn("mid", Q0);
      exp_a = '{EV_START, 'h92, 'h96, 'hAA, 'hCC, EV_STOP, 0, 0};
      chk_log("mid", 6);
      chk("mid.nack", nack, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
